// File: rtl/pci_slave_if.sv
// Handshake and control signals shared between a PCI-style initiator and target.
// AD stays a plain inout port on the target because it is bidirectional.
interface pci_slave_if;
    logic [3:0] CBE;
    logic       FRAME;
    logic       IRDY;
    logic       TRDY;
    logic       DEVSEL;

    modport master (output CBE, output FRAME, output IRDY, input TRDY, input DEVSEL);
    modport slave  (input CBE, input FRAME, input IRDY, output TRDY, output DEVSEL);
endinterface

// File: rtl/pci_slave.sv
// 32-bit PCI-style bus target backed by a small register-file memory.
// Claims decoded read/write commands and completes single or burst data phases.
module pci_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] DECODE_MASK = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [31:0] AD,
    pci_slave_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StWriteData,
        StReadTa,
        StReadData,
        StBusy,
        StTurn
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] ptr_q;
    logic [31:0]     mem_q [MEM_DEPTH];
    logic            trdy_q;
    logic            devsel_q;

    logic hit;
    logic cmd_rd;
    logic cmd_wr;
    logic xfer;
    logic abort;

    assign cmd_rd = (bus.CBE == 4'b0010);
    assign cmd_wr = (bus.CBE == 4'b0011);
    assign hit    = (((AD ^ BASE_ADDR) & DECODE_MASK) == 32'h0);
    assign xfer   = ((state_q == StWriteData) || (state_q == StReadData)) &&
                    !bus.IRDY && !trdy_q;
    assign abort  = bus.FRAME && bus.IRDY;

    assign bus.TRDY   = trdy_q;
    assign bus.DEVSEL = devsel_q;

    // Only READ_DATA drives the shared bus; reset forces StIdle, so release is immediate.
    assign AD = (state_q == StReadData) ? mem_q[ptr_q] : 32'hzzzz_zzzz;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            ptr_q    <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.FRAME) begin
                        ptr_q <= AD[IdxW+1:2];
                        if (hit && cmd_wr) begin
                            state_q  <= StWriteData;
                            devsel_q <= 1'b0;
                            trdy_q   <= 1'b0;
                        end else if (hit && cmd_rd) begin
                            state_q  <= StReadTa;
                            devsel_q <= 1'b0;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StReadTa: begin
                    if (abort) begin
                        state_q  <= StTurn;
                        devsel_q <= 1'b1;
                    end else begin
                        state_q <= StReadData;
                        trdy_q  <= 1'b0;
                    end
                end
                StWriteData, StReadData: begin
                    if (xfer) begin
                        if (state_q == StWriteData) begin
                            for (int b = 0; b < 4; b++) begin
                                if (!bus.CBE[b]) begin
                                    mem_q[ptr_q][8*b +: 8] <= AD[8*b +: 8];
                                end
                            end
                        end
                        ptr_q <= ptr_q + 1'b1;
                        // FRAME already high marks this as the final data phase.
                        if (bus.FRAME) begin
                            state_q  <= StTurn;
                            trdy_q   <= 1'b1;
                            devsel_q <= 1'b1;
                        end
                    end else if (abort) begin
                        state_q  <= StTurn;
                        trdy_q   <= 1'b1;
                        devsel_q <= 1'b1;
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                end
                StBusy: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pci_slave.sv
// Self-checking bench for pci_slave: bus-cycle tasks, a word-level memory model and a
// read-data scoreboard. A pullup on AD makes a released bus read back as all ones.
module tb_pci_slave;
    localparam logic [31:0] Base = 32'h0000_0100;
    localparam logic [31:0] Zval = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        tb_oe;
    logic [31:0] tb_ad;
    wire  [31:0] ad;

    assign ad = tb_oe ? tb_ad : 32'hzzzz_zzzz;
    pullup (ad);

    pci_slave_if bus ();

    pci_slave #(
        .BASE_ADDR  (Base),
        .DECODE_MASK(32'hFFFF_FF00),
        .MEM_DEPTH  (16)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .AD (ad),
        .bus(bus)
    );

    int          n_checks;
    int          n_fails;
    logic [31:0] model_mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] wdata [8];
    logic [3:0]  wbe [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0000;
        tb_oe     = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input int n, input int wait_at);
        logic [3:0] idx;
        idx       = addr[5:2];
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0011;
        tb_ad     = addr;
        tb_oe     = 1'b1;
        step();
        check("wr_devsel", 32'(bus.DEVSEL), 32'h0);
        check("wr_trdy", 32'(bus.TRDY), 32'h0);
        for (int i = 0; i < n; i++) begin
            if (i == wait_at) begin
                bus.IRDY = 1'b1;
                bus.CBE  = 4'b0000;
                tb_ad    = 32'hBAD0_0BAD;
                step();
                step();
                check("wr_wait_trdy", 32'(bus.TRDY), 32'h0);
            end
            bus.IRDY  = 1'b0;
            bus.CBE   = wbe[i];
            tb_ad     = wdata[i];
            bus.FRAME = (i == n - 1);
            step();
            for (int b = 0; b < 4; b++) begin
                if (!wbe[i][b]) model_mem[idx][8*b +: 8] = wdata[i][8*b +: 8];
            end
            idx = idx + 4'd1;
        end
        bus_idle();
        check("wr_end_trdy", 32'(bus.TRDY), 32'h1);
        check("wr_end_devsel", 32'(bus.DEVSEL), 32'h1);
        step();
    endtask

    task automatic bus_read(input logic [31:0] addr, input int n, input int wait_at);
        logic [3:0] idx;
        idx = addr[5:2];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_mem[idx]);
            idx = idx + 4'd1;
        end
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0010;
        tb_ad     = addr;
        tb_oe     = 1'b1;
        step();
        tb_oe     = 1'b0;
        bus.IRDY  = 1'b0;
        bus.FRAME = (n == 1);
        bus.CBE   = 4'b0000;
        #1;
        check("rd_ta_devsel", 32'(bus.DEVSEL), 32'h0);
        check("rd_ta_trdy", 32'(bus.TRDY), 32'h1);
        check("rd_ta_ad_z", ad, Zval);
        step();
        for (int i = 0; i < n; i++) begin
            if (i == wait_at) begin
                bus.IRDY = 1'b1;
                step();
                step();
                check("rd_wait_trdy", 32'(bus.TRDY), 32'h0);
            end
            bus.IRDY  = 1'b0;
            bus.FRAME = (i == n - 1);
            #1;
            if (bus.TRDY === 1'b0 && exp_q.size() > 0) begin
                check("rd_data", ad, exp_q.pop_front());
            end else begin
                check("rd_trdy", 32'(bus.TRDY), 32'h0);
            end
            step();
        end
        bus_idle();
        #1;
        check("rd_end_trdy", 32'(bus.TRDY), 32'h1);
        check("rd_end_devsel", 32'(bus.DEVSEL), 32'h1);
        check("rd_end_ad_z", ad, Zval);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        tb_ad    = 32'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        rst = 1'b1;
        bus_idle();
        #1;
        check("rst_trdy", 32'(bus.TRDY), 32'h1);
        check("rst_devsel", 32'(bus.DEVSEL), 32'h1);
        check("rst_ad_z", ad, Zval);
        step();
        step();
        rst = 1'b0;
        step();

        bus_read(Base, 1, -1);

        wdata[0] = 32'hDEAD_BEEF;
        wbe[0]   = 4'b0000;
        bus_write(Base + 32'h08, 1, -1);
        bus_read(Base + 32'h08, 1, -1);

        wdata[0] = 32'h1122_3344;
        wbe[0]   = 4'b1011;
        bus_write(Base + 32'h14, 1, -1);
        bus_read(Base + 32'h14, 1, -1);

        for (int i = 0; i < 3; i++) begin
            wdata[i] = 32'(i + 1);
            wbe[i]   = 4'b0000;
        end
        bus_write(Base + 32'h3C, 3, -1);
        bus_read(Base + 32'h3C, 3, -1);

        for (int i = 0; i < 4; i++) begin
            wdata[i] = 32'hA5A5_0000 | 32'(i * 17 + 3);
            wbe[i]   = 4'b0000;
        end
        wbe[1] = 4'b0101;
        bus_write(Base + 32'h20, 4, 2);
        bus_read(Base + 32'h20, 4, 1);

        // Read miss outside the decoded window
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0010;
        tb_ad     = 32'h0000_0200;
        tb_oe     = 1'b1;
        step();
        tb_oe    = 1'b0;
        bus.IRDY = 1'b0;
        #1;
        check("miss_devsel", 32'(bus.DEVSEL), 32'h1);
        check("miss_trdy", 32'(bus.TRDY), 32'h1);
        check("miss_ad_z", ad, Zval);
        step();
        check("miss_devsel2", 32'(bus.DEVSEL), 32'h1);
        check("miss_ad_z2", ad, Zval);
        bus.FRAME = 1'b1;
        step();
        check("miss_devsel3", 32'(bus.DEVSEL), 32'h1);
        bus_idle();
        step();

        // Write miss must not touch memory (word index 2 aliases a hit address)
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0011;
        tb_ad     = 32'h0000_0208;
        tb_oe     = 1'b1;
        step();
        bus.IRDY  = 1'b0;
        bus.FRAME = 1'b1;
        bus.CBE   = 4'b0000;
        tb_ad     = 32'hFFFF_0000;
        step();
        check("wmiss_devsel", 32'(bus.DEVSEL), 32'h1);
        bus_idle();
        step();

        // Unsupported command inside the window is never claimed
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0110;
        tb_ad     = Base;
        tb_oe     = 1'b1;
        step();
        tb_oe = 1'b0;
        #1;
        check("unsup_devsel", 32'(bus.DEVSEL), 32'h1);
        check("unsup_ad_z", ad, Zval);
        bus_idle();
        step();
        step();
        bus_read(Base + 32'h08, 1, -1);

        // Reset in the middle of a read burst
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b1;
        bus.CBE   = 4'b0010;
        tb_ad     = Base;
        tb_oe     = 1'b1;
        step();
        tb_oe    = 1'b0;
        bus.IRDY = 1'b0;
        step();
        step();
        #1;
        check("prerst_ad", ad, model_mem[1]);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ad_z", ad, Zval);
        check("midrst_trdy", 32'(bus.TRDY), 32'h1);
        check("midrst_devsel", 32'(bus.DEVSEL), 32'h1);
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        bus_idle();
        step();
        rst = 1'b0;
        step();
        bus_read(Base, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pci_slave.md
Name: pci_slave

Overview:
- 32-bit PCI-style bus target with an internal register-file memory.
- Decodes the address phase on the multiplexed AD bus and claims the transaction with DEVSEL.
- Completes single or burst read/write data phases using the FRAME/IRDY/TRDY handshake. All bus control signals are active-low.
- Sits on the shared bus behind an initiator; AD is bidirectional and driven by this block only during read data phases.

Parameters:
- BASE_ADDR, 32'h0000_0000, base address compared during decode.
- DECODE_MASK, 32'h0000_0000, bits of AD compared against BASE_ADDR. A mask of 0 claims every address.
- MEM_DEPTH, 16, number of 32-bit words (power of two). Word index = AD[log2(MEM_DEPTH)+1:2].

Ports:
- CLK  input  1  bus clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- AD  inout  32  multiplexed address/data bus.
- CBE  input  4  command in address phase; active-low byte enables in data phases.
- FRAME  input  1  active-low; asserted by the initiator for the transaction, deasserted before the last data phase.
- IRDY  input  1  active-low initiator ready.
- TRDY  output  1  active-low target ready.
- DEVSEL  output  1  active-low device select.

Behaviour:
- Reset (RST=1, async): state IDLE, TRDY=1, DEVSEL=1, AD high-Z, all memory words = 0, address pointer = 0. Applying reset mid-transaction aborts it immediately with the same values.
- Commands:
  - 4'b0010 = read.
  - 4'b0011 = write.
  - All other codes are unsupported and never claimed.
- Hit: ((AD ^ BASE_ADDR) & DECODE_MASK) == 0, with the command supported.
- States: IDLE, WRITE_DATA, READ_TA, READ_DATA, BUSY, TURN.
- IDLE:
  - On an edge with FRAME=0: latch ptr = word index from AD and latch the command.
  - Hit and write: go to WRITE_DATA; DEVSEL=0 and TRDY=0 from this edge.
  - Hit and read: go to READ_TA; DEVSEL=0, TRDY stays 1. This is the turnaround cycle and AD is not driven.
  - Miss or unsupported: go to BUSY.
- READ_TA: on the next edge go to READ_DATA; TRDY=0.
- READ_DATA:
  - AD is driven combinationally with mem[ptr] for the whole state. Byte enables are ignored on reads.
- Transfer: occurs on any edge in WRITE_DATA or READ_DATA with IRDY=0 and TRDY=0.
  - Write: for each byte n with CBE[n]=0, mem[ptr][8n+7:8n] <= AD[8n+7:8n]. Bytes with CBE[n]=1 are unchanged.
  - Both directions: ptr <= ptr+1, wrapping modulo MEM_DEPTH.
  - IRDY=1 inserts initiator wait states. The target never inserts wait states after the first data phase.
- Last phase: a transfer with FRAME=1 moves to TURN with TRDY=1 and DEVSEL=1 on that edge. AD is released to high-Z in TURN.
- TURN: return to IDLE on the next edge.
- BUSY: TRDY and DEVSEL stay 1 and AD stays high-Z. Return to IDLE on an edge with FRAME=1 and IRDY=1.
- FRAME=1 and IRDY=1 while in WRITE_DATA, READ_TA or READ_DATA (initiator abort): go to TURN without a transfer.
- AD is never driven outside READ_DATA.
- TRDY and DEVSEL are registered and glitch-free.

Test Plan:
- Reset: hold RST=1 -> TRDY=1, DEVSEL=1, AD=Z; reading word 0 afterwards returns 32'h0.
- Single write then read:
  - Write: addr 32'h0000_0008, CBE=0011, data 32'hDEAD_BEEF with CBE=0000, FRAME released with IRDY=0 -> DEVSEL low 1 edge after FRAME falls; mem[2]=DEAD_BEEF.
  - Read: read of 32'h0000_0008 (CBE=0010) -> one turnaround cycle with AD=Z, then AD=DEAD_BEEF with TRDY=0.
- Byte enables: write 32'h1122_3344 to word 5 with CBE=1011 after word 5 was 0 -> reading word 5 gives 32'h0022_0000.
- Burst and wrap: write 3 words starting at word 15 with data 1, 2, 3 -> words 15, 0, 1 hold 1, 2, 3; a burst read starting at word 15 returns 1, 2, 3 on consecutive transfers.
- Wait states and miss:
  - IRDY held high for 2 cycles mid-burst -> no ptr advance and no write.
  - With DECODE_MASK=32'hFFFF_FF00, BASE_ADDR=32'h100, access to 32'h200 -> DEVSEL stays 1 and AD stays Z until the bus is idle.
- Reset mid-burst: assert RST during READ_DATA -> AD goes high-Z and TRDY/DEVSEL go to 1 immediately, without waiting for a clock edge.
